multicycle_ctrl: RTL and testbench

- Multi-cycle sequencing controller for the 64-bit RISC-V datapath. It replaces single-cycle control with an FSM: FETCH, DECODE, EXEC, MEM, WB.
- It drives the enables for PC, IR, register file, ALU and data memory, and handshakes with a shared single-port memory through mem_req/mem_ready.
- It sits between the instruction register and datapath muxes, and raises a fault on a memory timeout.

---
 rtl/multicycle_ctrl_if.sv | 11 +
 rtl/multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the shared single-port memory.
// master: controller side (drives request/select/write, samples ready); slave: memory side.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_sel;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_req, output mem_sel, output mem_write, input mem_ready);
    modport slave  (input mem_req, input mem_sel, input mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 64-bit RISC-V datapath with memory timeout fault.
// Optional build macro ILLEGAL_TRAP_EN: illegal opcodes in DECODE raise fault and halt instead of acting as NOPs.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic                     zero,
    multicycle_ctrl_if.master        mem,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     pc_src,
    output logic                     reg_write,
    output logic                     alu_src,
    output logic [1:0]               alu_op,
    output logic                     mem_to_reg,
    output logic                     fault,
    output logic [2:0]               state_o
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_LD  = 3'd2,
        CL_ST  = 3'd3,
        CL_BEQ = 3'd4,
        CL_ILL = 3'd5
    } class_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    function automatic class_t classify(input logic [6:0] op);
        class_t c;
        case (op)
            7'b0110011: c = CL_R;
            7'b0010011: c = CL_I;
            7'b0000011: c = CL_LD;
            7'b0100011: c = CL_ST;
            7'b1100011: c = CL_BEQ;
            default:    c = CL_ILL;
        endcase
        return c;
    endfunction

    state_t             state_q, state_d;
    class_t             class_q, class_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;

    logic               mem_req_s, mem_sel_s, mem_write_s;
    logic               ir_write_s, pc_write_s, pc_src_s, reg_write_s;
    logic               alu_src_s, mem_to_reg_s;
    logic [1:0]         alu_op_s;
    logic               wait_s;

    // State, latched opcode class, wait counter and sticky fault registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            class_q <= CL_R;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Next-state, raw strobes and wait-counter update
    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        fault_d      = fault_q;
        cnt_d        = cnt_q;
        mem_req_s    = 1'b0;
        mem_sel_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_s    = 1'b0;
        alu_op_s     = 2'b00;
        mem_to_reg_s = 1'b0;
        wait_s       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req_s = 1'b1;
                if (mem.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = ST_DECODE;
                end else if (cnt_q == CNT_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_s = 1'b1;
                end
            end
            ST_DECODE: begin
                class_d = classify(opcode);
                if (class_d == CL_ILL) begin
`ifdef ILLEGAL_TRAP_EN
                    fault_d = 1'b1;
                    state_d = ST_HALT;
`else
                    state_d = ST_FETCH;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CL_R: begin
                        alu_op_s = 2'b10;
                        state_d  = ST_WB;
                    end
                    CL_I: begin
                        alu_src_s = 1'b1;
                        alu_op_s  = 2'b10;
                        state_d   = ST_WB;
                    end
                    CL_LD, CL_ST: begin
                        alu_src_s = 1'b1;
                        state_d   = ST_MEM;
                    end
                    CL_BEQ: begin
                        // Branch target adder holds the PC of this instruction
                        alu_op_s   = 2'b01;
                        pc_write_s = zero;
                        pc_src_s   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req_s   = 1'b1;
                mem_sel_s   = 1'b1;
                mem_write_s = (class_q == CL_ST);
                alu_src_s   = 1'b1;
                if (mem.mem_ready) begin
                    state_d = (class_q == CL_ST) ? ST_FETCH : ST_WB;
                end else if (cnt_q == CNT_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_s = 1'b1;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = (class_q == CL_LD);
                state_d      = ST_FETCH;
            end
            ST_HALT: begin
                fault_d = 1'b1;
                state_d = ST_HALT;
            end
            default: begin
                // Unreachable encodings are treated as a corrupted state
                fault_d = 1'b1;
                state_d = ST_HALT;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (wait_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Strobes are forced low while reset is held so an abort is visible immediately
    always_comb begin
        if (reset) begin
            mem.mem_req   = mem_req_s;
            mem.mem_sel   = mem_sel_s;
            mem.mem_write = mem_write_s;
            ir_write      = ir_write_s;
            pc_write      = pc_write_s;
            pc_src        = pc_src_s;
            reg_write     = reg_write_s;
            alu_src       = alu_src_s;
            alu_op        = alu_op_s;
            mem_to_reg    = mem_to_reg_s;
        end else begin
            mem.mem_req   = 1'b0;
            mem.mem_sel   = 1'b0;
            mem.mem_write = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 1'b0;
            reg_write     = 1'b0;
            alu_src       = 1'b0;
            alu_op        = 2'b00;
            mem_to_reg    = 1'b0;
        end
    end

    assign fault   = fault_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand-computed state/strobe vectors checked cycle by cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       ir_write, pc_write, pc_src, reg_write, alu_src, mem_to_reg, fault;
    logic [1:0] alu_op;
    logic [2:0] state_o;
    logic [11:0] outv;
    int tests = 0;
    int fails = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (mif.master),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .fault      (fault),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    assign outv = {mif.mem_req, mif.mem_sel, mif.mem_write, ir_write, pc_write, pc_src,
                   reg_write, alu_src, alu_op, mem_to_reg, fault};

    // Expected output vector in the same bit order as outv
    function automatic logic [11:0] ev(input logic req, input logic sel, input logic wr,
                                       input logic ir, input logic pcw, input logic pcs,
                                       input logic rw, input logic as, input logic [1:0] op,
                                       input logic m2r, input logic f);
        return {req, sel, wr, ir, pcw, pcs, rw, as, op, m2r, f};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check state and strobes, advance past the edge
    task automatic cyc(input string tag, input logic [6:0] opc, input logic z, input logic rdy,
                       input logic [2:0] es, input logic [11:0] e);
        opcode = opc;
        zero = z;
        mif.mem_ready = rdy;
        #1;
        chk({tag, "/state"}, {13'd0, state_o}, {13'd0, es});
        chk({tag, "/out"}, {4'd0, outv}, {4'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        mif.mem_ready = 1'b1;
        #1;
        chk({tag, "/state"}, {13'd0, state_o}, 16'd0);
        chk({tag, "/out"}, {4'd0, outv}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        opcode = OP_R;
        zero = 1'b0;
        mif.mem_ready = 1'b1;
        #3;
        chk("reset/state", {13'd0, state_o}, 16'd0);
        chk("reset/out", {4'd0, outv}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // R-type with immediate memory
        cyc("r_fetch",  OP_R, 1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));
        cyc("r_decode", OP_R, 1'b0, 1'b1, 3'd1, ev(0,0,0,0,0,0,0,0,2'b00,0,0));
        cyc("r_exec",   OP_R, 1'b0, 1'b1, 3'd2, ev(0,0,0,0,0,0,0,0,2'b10,0,0));
        cyc("r_wb",     OP_R, 1'b0, 1'b1, 3'd4, ev(0,0,0,0,0,0,1,0,2'b00,0,0));

        // Load with three wait cycles in MEM; IR changes after DECODE must be ignored
        cyc("ld_fetch",  OP_LD, 1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));
        cyc("ld_decode", OP_LD, 1'b0, 1'b1, 3'd1, ev(0,0,0,0,0,0,0,0,2'b00,0,0));
        cyc("ld_exec",   OP_R,  1'b0, 1'b1, 3'd2, ev(0,0,0,0,0,0,0,1,2'b00,0,0));
        for (int i = 0; i < 3; i++)
            cyc("ld_memwait", OP_R, 1'b0, 1'b0, 3'd3, ev(1,1,0,0,0,0,0,1,2'b00,0,0));
        cyc("ld_memrdy", OP_R, 1'b0, 1'b1, 3'd3, ev(1,1,0,0,0,0,0,1,2'b00,0,0));
        cyc("ld_wb",     OP_R, 1'b0, 1'b1, 3'd4, ev(0,0,0,0,0,0,1,0,2'b00,1,0));

        // Store
        cyc("st_fetch",  OP_ST, 1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));
        cyc("st_decode", OP_ST, 1'b0, 1'b1, 3'd1, ev(0,0,0,0,0,0,0,0,2'b00,0,0));
        cyc("st_exec",   OP_ST, 1'b0, 1'b1, 3'd2, ev(0,0,0,0,0,0,0,1,2'b00,0,0));
        cyc("st_mem",    OP_ST, 1'b0, 1'b1, 3'd3, ev(1,1,1,0,0,0,0,1,2'b00,0,0));

        // beq taken then not taken
        cyc("beq1_fetch",  OP_BEQ, 1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));
        cyc("beq1_decode", OP_BEQ, 1'b0, 1'b1, 3'd1, ev(0,0,0,0,0,0,0,0,2'b00,0,0));
        cyc("beq1_exec",   OP_BEQ, 1'b1, 1'b1, 3'd2, ev(0,0,0,0,1,1,0,0,2'b01,0,0));
        cyc("beq0_fetch",  OP_BEQ, 1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));
        cyc("beq0_decode", OP_BEQ, 1'b0, 1'b1, 3'd1, ev(0,0,0,0,0,0,0,0,2'b00,0,0));
        cyc("beq0_exec",   OP_BEQ, 1'b0, 1'b1, 3'd2, ev(0,0,0,0,0,1,0,0,2'b01,0,0));

        // Ready arriving on the 15th FETCH cycle wins over the timeout
        for (int i = 0; i < 14; i++)
            cyc("nm_wait", OP_R, 1'b0, 1'b0, 3'd0, ev(1,0,0,0,0,0,0,0,2'b00,0,0));
        cyc("nm_rdy",    OP_R, 1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));
        cyc("nm_decode", OP_R, 1'b0, 1'b1, 3'd1, ev(0,0,0,0,0,0,0,0,2'b00,0,0));
        cyc("nm_exec",   OP_R, 1'b0, 1'b1, 3'd2, ev(0,0,0,0,0,0,0,0,2'b10,0,0));
        cyc("nm_wb",     OP_R, 1'b0, 1'b1, 3'd4, ev(0,0,0,0,0,0,1,0,2'b00,0,0));

        // FETCH timeout after exactly 15 wait cycles, then absorbing HALT
        for (int i = 0; i < 15; i++)
            cyc("to_wait", OP_R, 1'b0, 1'b0, 3'd0, ev(1,0,0,0,0,0,0,0,2'b00,0,0));
        cyc("to_halt0", OP_R, 1'b0, 1'b1, 3'd5, ev(0,0,0,0,0,0,0,0,2'b00,0,1));
        cyc("to_halt1", OP_R, 1'b0, 1'b1, 3'd5, ev(0,0,0,0,0,0,0,0,2'b00,0,1));
        do_reset("to_reset");

        // Illegal opcode
        cyc("ill_fetch",  OP_BAD, 1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));
        cyc("ill_decode", OP_BAD, 1'b0, 1'b1, 3'd1, ev(0,0,0,0,0,0,0,0,2'b00,0,0));
`ifdef ILLEGAL_TRAP_EN
        cyc("ill_halt",   OP_R,   1'b0, 1'b1, 3'd5, ev(0,0,0,0,0,0,0,0,2'b00,0,1));
`else
        cyc("ill_nop",    OP_R,   1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));
`endif
        do_reset("ill_reset");

        // Reset asserted while waiting in MEM aborts immediately
        cyc("ab_fetch",  OP_LD, 1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));
        cyc("ab_decode", OP_LD, 1'b0, 1'b1, 3'd1, ev(0,0,0,0,0,0,0,0,2'b00,0,0));
        cyc("ab_exec",   OP_LD, 1'b0, 1'b1, 3'd2, ev(0,0,0,0,0,0,0,1,2'b00,0,0));
        mif.mem_ready = 1'b0;
        #1;
        chk("ab_mem/out", {4'd0, outv}, {4'd0, ev(1,1,0,0,0,0,0,1,2'b00,0,0)});
        #2;
        reset = 1'b0;
        mif.mem_ready = 1'b1;
        #1;
        chk("ab_async/state", {13'd0, state_o}, 16'd0);
        chk("ab_async/out", {4'd0, outv}, 16'd0);
        @(posedge clk);
        #1;
        chk("ab_held/out", {4'd0, outv}, 16'd0);
        reset = 1'b1;
        cyc("ab_restart", OP_R, 1'b0, 1'b1, 3'd0, ev(1,0,0,1,1,0,0,0,2'b00,0,0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
